// File: rtl/game_timer.sv
`default_nettype none
// ============================================================================
// Module   : game_timer
// Purpose  : Prescaled countdown timer with load/run/pause control. A
//            prescaler divides clk_in by DIV = CLK_HZ/TICK_HZ. Each prescaler
//            wrap in RUN decrements 'remaining'. 'expired' pulses on reaching
//            zero.
// Ports    : clk_in    - single clock, rising edge
//            reset     - synchronous, active-high
//            start     - load-and-run strobe (priority over pause/tick)
//            pause     - level-sensitive hold request
//            load_val  - countdown start value, sampled when start=1
//            tick_out  - one-cycle pulse per countdown tick
//            remaining - current countdown value
//            running   - high only in RUN
//            expired   - one-cycle pulse on reaching zero
//            bcd_out   - three BCD digits of remaining (GAME_TIMER_BCD_EN only)
// Options  : define GAME_TIMER_BCD_EN to add bcd_out (requires CNT_W <= 8)
// Revision : 1.0 - initial release
// ============================================================================
module game_timer #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             start,
    input  logic             pause,
    input  logic [CNT_W-1:0] load_val,
    output logic             tick_out,
    output logic [CNT_W-1:0] remaining,
    output logic             running,
    output logic             expired
`ifdef GAME_TIMER_BCD_EN
    ,
    output logic [11:0]      bcd_out
`endif
);

    localparam int c_DIV  = CLK_HZ / TICK_HZ;
    localparam int c_PS_W = $clog2(c_DIV);
    localparam logic [c_PS_W-1:0] c_PS_MAX = c_PS_W'(c_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [c_PS_W-1:0]  ps_q, ps_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               expired_q, expired_d;
    logic               w_tick;

    // Tick decoded purely from registered state so no input reaches tick_out.
    assign w_tick = (state_q == S_RUN) && (ps_q == c_PS_MAX);

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ps_q      <= '0;
            rem_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ps_q      <= ps_d;
            rem_q     <= rem_d;
            expired_q <= expired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ps_d      = ps_q;
        rem_d     = rem_q;
        expired_d = 1'b0;

        if (start) begin
            // Start wins over pause and any pending tick.
            rem_d = load_val;
            ps_d  = '0;
            if (load_val != '0) begin
                state_d = S_RUN;
            end else begin
                state_d   = S_DONE;
                expired_d = 1'b1;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    ps_d = '0;
                end
                S_RUN: begin
                    if (w_tick) begin
                        ps_d = '0;
                        if (rem_q <= CNT_W'(1)) begin
                            rem_d     = '0;
                            state_d   = S_DONE;
                            expired_d = 1'b1;
                        end else begin
                            rem_d = rem_q - CNT_W'(1);
                        end
                    end else begin
                        ps_d = ps_q + c_PS_W'(1);
                    end
                    // Pause still lets this cycle's tick land; reaching zero
                    // takes precedence and the timer finishes instead.
                    if (pause && (state_d == S_RUN)) begin
                        state_d = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    // Prescaler holds, so resuming loses no elapsed time.
                    if (!pause) begin
                        state_d = S_RUN;
                    end
                end
                S_DONE: begin
                    ps_d  = '0;
                    rem_d = '0;
                end
                default: begin
                    state_d = S_IDLE;
                    ps_d    = '0;
                    rem_d   = '0;
                end
            endcase
        end
    end

    assign tick_out  = w_tick;
    assign remaining = rem_q;
    assign running   = (state_q == S_RUN);
    assign expired   = expired_q;

`ifdef GAME_TIMER_BCD_EN
    logic [7:0] w_bin;

    assign w_bin   = 8'(rem_q);
    // Constant divisors keep this a small combinational converter.
    assign bcd_out = {4'(w_bin / 8'd100),
                      4'((w_bin % 8'd100) / 8'd10),
                      4'(w_bin % 8'd10)};
`endif

endmodule
`default_nettype wire

// File: tb/tb_game_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_timer
// Purpose  : Directed self-checking bench for game_timer with CLK_HZ=10,
//            TICK_HZ=1 (DIV=10). Cycle c is the clock period following the
//            c-th rising edge after the scenario begins; inputs are applied
//            and outputs checked 1 time unit after that edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_timer;

    localparam int CLK_HZ  = 10;
    localparam int TICK_HZ = 1;
    localparam int CNT_W   = 8;

    logic             clk      = 1'b0;
    logic             reset    = 1'b1;
    logic             start    = 1'b0;
    logic             pause    = 1'b0;
    logic [CNT_W-1:0] load_val = '0;
    logic             tick_out;
    logic [CNT_W-1:0] remaining;
    logic             running;
    logic             expired;
`ifdef GAME_TIMER_BCD_EN
    logic [11:0]      bcd_out;
`endif

    int    n_checks = 0;
    int    n_pass   = 0;
    string scn      = "";

    always #5 clk = ~clk;

    game_timer #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_in    (clk),
        .reset     (reset),
        .start     (start),
        .pause     (pause),
        .load_val  (load_val),
        .tick_out  (tick_out),
        .remaining (remaining),
        .running   (running),
        .expired   (expired)
`ifdef GAME_TIMER_BCD_EN
        ,
        .bcd_out   (bcd_out)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", tag, got, exp);
    endtask

    task automatic chk_outs(input int c, input bit t, input int r, input bit run, input bit e);
        check($sformatf("%s c%0d tick_out", scn, c), 32'(tick_out), 32'(t));
        check($sformatf("%s c%0d remaining", scn, c), 32'(remaining), 32'(r));
        check($sformatf("%s c%0d running", scn, c), 32'(running), 32'(run));
        check($sformatf("%s c%0d expired", scn, c), 32'(expired), 32'(e));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        pause = 1'b0;
        step();
        step();
        reset = 1'b0;
        chk_outs(-1, 1'b0, 0, 1'b0, 1'b0);
    endtask

    // load 3, start in cycle 0, no pause
    task automatic run_basic();
        int r;
        for (int c = 0; c <= 35; c++) begin
            start    = (c == 0);
            load_val = 8'd3;
            pause    = 1'b0;
            r = (c == 0) ? 0 : (c < 11) ? 3 : (c < 21) ? 2 : (c < 31) ? 1 : 0;
            chk_outs(c, (c == 10 || c == 20 || c == 30), r,
                     (c >= 1 && c < 31), (c == 31));
            step();
        end
        start = 1'b0;
    endtask

    initial begin
        int r;

        scn = "reset";
        do_reset();

        scn = "basic";
        run_basic();

        // pause high in cycles 15..39 shifts later ticks by 25 cycles
        scn = "pause";
        do_reset();
        for (int c = 0; c <= 60; c++) begin
            start    = (c == 0);
            load_val = 8'd3;
            pause    = (c >= 15 && c <= 39);
            r = (c == 0) ? 0 : (c < 11) ? 3 : (c < 46) ? 2 : (c < 56) ? 1 : 0;
            chk_outs(c, (c == 10 || c == 45 || c == 55), r,
                     ((c >= 1 && c <= 15) || (c >= 41 && c <= 55)), (c == 56));
            step();
        end
        pause = 1'b0;
        start = 1'b0;

        // zero load goes straight to DONE and stays there
        scn = "zero";
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            start    = (c == 0);
            load_val = 8'd0;
            chk_outs(c, 1'b0, 0, 1'b0, (c == 1));
            step();
        end
        start = 1'b0;

        // restart at remaining=2, prescaler=7 (cycle 18), with pause also high
        scn = "restart";
        do_reset();
        for (int c = 0; c <= 40; c++) begin
            start    = (c == 0 || c == 18);
            load_val = (c == 18) ? 8'd5 : 8'd3;
            pause    = (c == 18);
            r = (c == 0) ? 0 : (c < 11) ? 3 : (c < 19) ? 2 : (c < 29) ? 5 : (c < 39) ? 4 : 3;
            chk_outs(c, (c == 10 || c == 28 || c == 38), r, (c >= 1), 1'b0);
            step();
        end
        start = 1'b0;
        pause = 1'b0;

        // reset mid-run in cycle 14, then a fresh run
        scn = "midreset";
        do_reset();
        for (int c = 0; c <= 16; c++) begin
            start    = (c == 0);
            load_val = 8'd3;
            reset    = (c == 14);
            r = (c == 0) ? 0 : (c < 11) ? 3 : (c < 15) ? 2 : 0;
            chk_outs(c, (c == 10), r, (c >= 1 && c < 15), 1'b0);
            step();
        end
        reset = 1'b0;
        start = 1'b0;
        scn = "afterreset";
        run_basic();

        // reset while paused
        scn = "pausereset";
        do_reset();
        for (int c = 0; c <= 8; c++) begin
            start    = (c == 0);
            load_val = 8'd7;
            pause    = (c >= 3);
            reset    = (c == 6);
            r = (c == 0 || c >= 7) ? 0 : 7;
            chk_outs(c, 1'b0, r, (c >= 1 && c <= 3), 1'b0);
            step();
        end
        reset = 1'b0;
        pause = 1'b0;
        start = 1'b0;

`ifdef GAME_TIMER_BCD_EN
        scn = "bcd";
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            start    = (c == 0);
            load_val = 8'd213;
            if (c == 1 || c == 10)
                check($sformatf("bcd c%0d", c), 32'(bcd_out), 32'h213);
            if (c == 11)
                check($sformatf("bcd c%0d", c), 32'(bcd_out), 32'h212);
            step();
        end
        start    = 1'b1;
        load_val = 8'd255;
        step();
        start = 1'b0;
        check("bcd 255", 32'(bcd_out), 32'h255);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
